// File: rtl/text_vram_arbiter.sv
// Text tile RAM arbiter: per-character video prefetch (absolute priority),
// screen-clear sequencer and a host read/write port sharing one RAM port.
module text_vram_arbiter #(
  parameter int unsigned H_CHARS  = 80,
  parameter int unsigned V_CHARS  = 30,
  parameter int unsigned H_TOTAL  = 800,
  parameter int unsigned V_TOTAL  = 525,
  parameter int unsigned V_DISP   = 480,
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned DATA_W   = 7,
  parameter logic [DATA_W-1:0] CLR_CHAR = 7'h20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        pixel_x,
  input  logic [9:0]        pixel_y,
  input  logic              pixel_tick,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [DATA_W-1:0] char_code
);

  localparam int unsigned LAST_CELL  = H_CHARS * V_CHARS - 1;
  localparam int unsigned LAST_CELLX = H_TOTAL / 8 - 1;

  typedef enum logic {IDLE, CLEAR} state_t;
  typedef enum logic [1:0] {TAG_NONE, TAG_VIDEO, TAG_HOST} tag_t;

  state_t              state, next_state;
  tag_t                tag1, tag2;
  logic [ADDR_W-1:0]   clr_addr;
  logic [DATA_W-1:0]   char_next;
  logic                vid_pend;

  logic [6:0]          cell_x, vid_col;
  logic [9:0]          next_line, vid_line;
  logic [ADDR_W-1:0]   vid_addr;
  logic                vid_read, char_load;
  logic                clr_we, host_go;

  assign cell_x = pixel_x[9:3];

  // Prefetch target: the cell after the current one, wrapping to the next line
  always_comb begin
    next_line = (pixel_y == 10'(V_TOTAL - 1)) ? 10'd0 : pixel_y + 10'd1;
    if (cell_x == 7'(LAST_CELLX)) begin
      vid_col  = 7'd0;
      vid_line = next_line;
    end else begin
      vid_col  = cell_x + 7'd1;
      vid_line = pixel_y;
    end
    vid_addr  = ADDR_W'(vid_line[8:4]) * ADDR_W'(H_CHARS) + ADDR_W'(vid_col);
    vid_read  = pixel_tick && (pixel_x[2:0] == 3'd5) &&
                (vid_col < 7'(H_CHARS)) && (vid_line < 10'(V_DISP));
    char_load = pixel_tick && (pixel_x[2:0] == 3'd7);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Owner selection for non-video cycles
  always_comb begin
    next_state = state;
    clr_we     = 1'b0;
    host_go    = 1'b0;
    case (state)
      IDLE: begin
        if (clr_start)                  next_state = CLEAR;
        else if (host_req && !vid_read) host_go = 1'b1;
      end
      CLEAR: begin
        if (!vid_read) begin
          clr_we = 1'b1;
          if (clr_addr == ADDR_W'(LAST_CELL)) next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_addr    <= '0;
      ram_we      <= 1'b0;
      ram_din     <= '0;
      tag1        <= TAG_NONE;
      tag2        <= TAG_NONE;
      host_ack    <= 1'b0;
      host_rvalid <= 1'b0;
      host_rdata  <= '0;
      clr_busy    <= 1'b0;
      clr_addr    <= '0;
      char_next   <= '0;
      char_code   <= '0;
      vid_pend    <= 1'b0;
    end else begin
      ram_we   <= 1'b0;
      tag1     <= TAG_NONE;
      if (vid_read) begin
        ram_addr <= vid_addr;
        tag1     <= TAG_VIDEO;
      end else if (clr_we) begin
        ram_addr <= clr_addr;
        ram_we   <= 1'b1;
        ram_din  <= CLR_CHAR;
      end else if (host_go) begin
        ram_addr <= host_addr;
        ram_we   <= host_we;
        ram_din  <= host_wdata;
        tag1     <= host_we ? TAG_NONE : TAG_HOST;
      end
      host_ack <= host_go;
      clr_busy <= (next_state == CLEAR);

      if (state == IDLE && clr_start) clr_addr <= '0;
      else if (clr_we)                clr_addr <= clr_addr + ADDR_W'(1);

      // Read data returns two edges after issue; route it by tag
      tag2        <= tag1;
      host_rvalid <= (tag2 == TAG_HOST);
      if (tag2 == TAG_HOST)  host_rdata <= ram_dout;
      if (tag2 == TAG_VIDEO) char_next  <= ram_dout;

      if (char_load) begin
        if (vid_pend) char_code <= char_next;
        vid_pend <= 1'b0;
      end
      if (vid_read) vid_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_text_vram_arbiter.sv
// Scoreboard bench for text_vram_arbiter: behavioural RAM, spec-level model of
// video prefetch, clear sequencer and host port; monitor checks every output.
module tb_text_vram_arbiter;
  localparam int H_CHARS = 80;
  localparam int V_CHARS = 30;
  localparam int H_TOTAL = 800;
  localparam int V_TOTAL = 525;
  localparam int V_DISP  = 480;
  localparam int CELLS   = H_CHARS * V_CHARS;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  pixel_x = '0, pixel_y = '0;
  logic        pixel_tick = 1'b0;
  logic        host_req = 1'b0, host_we = 1'b0;
  logic [11:0] host_addr = '0;
  logic [6:0]  host_wdata = '0;
  logic        host_ack, host_rvalid, clr_busy, ram_we;
  logic [6:0]  host_rdata, ram_din, char_code;
  logic [6:0]  ram_dout = '0;
  logic [11:0] ram_addr;
  logic        clr_start = 1'b0;

  text_vram_arbiter dut (
    .clk(clk), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .pixel_tick(pixel_tick), .host_req(host_req), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_ack(host_ack),
    .host_rvalid(host_rvalid), .host_rdata(host_rdata), .clr_start(clr_start),
    .clr_busy(clr_busy), .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din),
    .ram_dout(ram_dout), .char_code(char_code)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int init_val(input int i);
    if (i == 81) return 'h41;
    return (i * 37 + 11) % 128;
  endfunction

  // Synchronous single-port RAM, read data registered one edge after address
  logic [6:0] mem [0:4095];
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 7'(init_val(i));
    forever begin
      @(posedge clk);
      if (ram_we) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
    end
  end

  typedef struct { bit we; int addr; int data; } hop_t;
  typedef struct { int data; int due; } rd_t;
  hop_t host_q[$];
  rd_t  rd_q[$];
  int   clr_q[$];

  // Which cell the prefetch slot at (x,y) wants, from the screen geometry
  function automatic void vid_target(input int x, input int y, output bit need, output int addr);
    int cx, col, line;
    cx = x / 8;
    if (cx == H_TOTAL / 8 - 1) begin
      col  = 0;
      line = (y == V_TOTAL - 1) ? 0 : y + 1;
    end else begin
      col  = cx + 1;
      line = y;
    end
    need = (x % 8 == 5) && (col < H_CHARS) && (line < V_DISP);
    addr = (line / 16) * H_CHARS + col;
  endfunction

  int  cyc = 0;
  bit  exp_busy = 0;

  // Monitor / scoreboard: model update at the edge, compare half a cycle later
  initial begin
    int  shadow [0:4095];
    bit  s_need, s_busy_pre, vpend, n;
    int  s_addr, vval, exp_char, a;
    hop_t o;
    rd_t  r;
    for (int i = 0; i < 4096; i++) shadow[i] = init_val(i);
    s_need = 0; s_busy_pre = 0; vpend = 0; vval = 0; exp_char = 0; s_addr = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (reset) begin
        s_need = 0; s_busy_pre = 0; vpend = 0; exp_char = 0; exp_busy = 0;
        host_q.delete(); rd_q.delete(); clr_q.delete();
      end else begin
        vid_target(int'(pixel_x), int'(pixel_y), n, a);
        s_need     = pixel_tick && n;
        s_addr     = a;
        s_busy_pre = exp_busy || clr_start;
        if (s_need) begin vpend = 1; vval = shadow[a]; end
        if (pixel_tick && pixel_x[2:0] == 3'd7) begin
          if (vpend) exp_char = vval;
          vpend = 0;
        end
        if (!exp_busy && clr_start) exp_busy = 1;
      end
      @(negedge clk);
      if (!reset) begin
        if (s_need) begin
          chk("video_we", int'(ram_we), 0);
          chk("video_addr", int'(ram_addr), s_addr);
        end
        if (host_ack) begin
          chk("ack_during_clear", int'(s_busy_pre), 0);
          if (host_q.size() == 0) chk("ack_unexpected", 1, 0);
          else begin
            o = host_q.pop_front();
            chk("host_addr", int'(ram_addr), o.addr);
            chk("host_we", int'(ram_we), int'(o.we));
            if (o.we) begin
              chk("host_din", int'(ram_din), o.data);
              shadow[o.addr] = o.data;
            end else rd_q.push_back('{data: shadow[o.addr], due: cyc + 2});
          end
        end else if (ram_we) begin
          if (clr_q.size() == 0) chk("stray_write", 1, 0);
          else begin
            a = clr_q.pop_front();
            chk("clr_addr", int'(ram_addr), a);
            chk("clr_data", int'(ram_din), 'h20);
            shadow[a] = 'h20;
            if (a == CELLS - 1) exp_busy = 0;
          end
        end
        if (host_rvalid) begin
          if (rd_q.size() == 0) chk("rvalid_unexpected", 1, 0);
          else begin
            r = rd_q.pop_front();
            chk("rdata", int'(host_rdata), r.data);
            chk("rvalid_cycle", cyc, r.due);
          end
        end
        chk("clr_busy", int'(clr_busy), int'(exp_busy));
        chk("char_code", int'(char_code), exp_char);
      end
    end
  end

  int px = 0, py = 0;

  task automatic tick1();
    @(posedge clk); #1;
    pixel_x = 10'(px); pixel_y = 10'(py); pixel_tick = 1'b1;
    @(posedge clk); #1;
    pixel_tick = 1'b0;
    px++;
    if (px == H_TOTAL) begin px = 0; py = (py == V_TOTAL - 1) ? 0 : py + 1; end
  endtask

  task automatic run_cells(input int ncells);
    for (int i = 0; i < ncells * 8; i++) begin
      tick1();
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
  endtask

  task automatic host_op(input bit we, input int a, input int d, input int max_lat, output int lat);
    bit done;
    @(posedge clk); #1;
    host_req = 1'b1; host_we = we; host_addr = 12'(a); host_wdata = 7'(d);
    host_q.push_back('{we: we, addr: a, data: d});
    lat = 0; done = 0;
    while (!done && lat < 6000) begin
      @(posedge clk); lat++;
      @(negedge clk); done = host_ack;
    end
    host_req = 1'b0;
    if (!done) chk("host_ack_timeout", 0, 1);
    else if (max_lat > 0) chk("host_wait_bound", int'(lat <= max_lat), 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"}, int'(host_ack), 0);
    chk({tag, "_rvalid"}, int'(host_rvalid), 0);
    chk({tag, "_rdata"}, int'(host_rdata), 0);
    chk({tag, "_busy"}, int'(clr_busy), 0);
    chk({tag, "_raddr"}, int'(ram_addr), 0);
    chk({tag, "_rwe"}, int'(ram_we), 0);
    chk({tag, "_rdin"}, int'(ram_din), 0);
    chk({tag, "_char"}, int'(char_code), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, prev;
    repeat (3) @(posedge clk); #1;
    chk_all_zero("reset");
    reset = 1'b0;

    // Row 1 scan: cell (1,1) at x=8..15 holds 0x41
    px = 0; py = 16;
    for (int x = 0; x < 16; x++) begin
      tick1();
      if (x == 5) chk("t2_prefetch_addr", int'(ram_addr), 81);
      if (x >= 7 && x <= 14) chk("t2_char", int'(char_code), 'h41);
    end

    // End-of-line prefetch wraps to the next text line
    px = 797; py = 15;  tick1(); chk("t4_addr_row1", int'(ram_addr), 80);
    px = 797; py = 524; tick1(); chk("t4_addr_wrap", int'(ram_addr), 0);
    prev = int'(ram_addr);
    px = 797; py = 479; tick1();
    chk("t4_no_read_addr", int'(ram_addr), prev);
    chk("t4_no_read_we", int'(ram_we), 0);

    // Host write colliding with a video slot waits one cycle
    px = 13; py = 40;
    fork
      tick1();
      host_op(1, 100, 'h55, 0, lat);
    join
    chk("t3_ack_latency", lat, 2);
    host_op(0, 100, 0, 2, lat);
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("t3_rvalid", int'(host_rvalid), 1);
    chk("t3_rdata", int'(host_rdata), 'h55);

    // Random host traffic against scanning video
    px = 8 * $urandom_range(0, 99); py = $urandom_range(0, V_TOTAL - 1);
    fork
      run_cells(30);
      for (int i = 0; i < 50; i++) begin
        int l;
        host_op(bit'($urandom_range(0, 1)), $urandom_range(0, CELLS - 1),
                $urandom_range(0, 127), 2, l);
      end
    join
    px = 760; py = V_TOTAL - 1;
    fork
      run_cells(12);
      for (int i = 0; i < 30; i++) begin
        int l;
        host_op(0, $urandom_range(0, CELLS - 1), 0, 2, l);
      end
    join

    // Screen clear with video running, a second start ignored, host held
    px = 8 * $urandom_range(0, 60); py = $urandom_range(0, 400);
    fork
      run_cells(40);
      begin
        int l;
        for (int i = 0; i < CELLS; i++) clr_q.push_back(i);
        @(posedge clk); #1 clr_start = 1'b1;
        @(posedge clk); #1 clr_start = 1'b0;
        repeat (50) @(posedge clk);
        #1 clr_start = 1'b1;
        @(posedge clk); #1 clr_start = 1'b0;
        host_op(0, 7, 0, 0, l);
        chk("clr_done_before_ack", int'(clr_busy), 0);
        chk("clr_all_written", clr_q.size(), 0);
      end
    join

    // Reset mid-frame with a host read in flight
    fork
      run_cells(6);
      begin
        int l;
        repeat (5) @(posedge clk);
        host_op(0, 300, 0, 2, l);
        #2 reset = 1'b1;
        #1 chk_all_zero("t1_async");
        @(posedge clk); @(posedge clk); #1 reset = 1'b0;
        repeat (6) begin
          @(negedge clk);
          chk("t1_no_rvalid", int'(host_rvalid), 0);
        end
      end
    join

    // Reset mid-clear abandons the sequence
    for (int i = 0; i < CELLS; i++) clr_q.push_back(i);
    @(posedge clk); #1 clr_start = 1'b1;
    @(posedge clk); #1 clr_start = 1'b0;
    repeat (100) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("clr_abandoned_busy", int'(clr_busy), 0);
    chk("clr_abandoned_we", int'(ram_we), 0);

    repeat (5) @(posedge clk);
    chk("queues_drained", host_q.size() + rd_q.size() + clr_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
